// File: rtl/int_to_float_converter.sv
// Memory-mapped int32 -> IEEE-754 single converter.
// Normalises one bit per cycle, then truncates the mantissa.
module int_to_float_converter (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Data_Addr,
   input  logic [31:0] Data_In,
   input  logic        MemWrite,
   output logic [31:0] Result
);

   localparam logic [31:0] ADDR_OPERAND = 32'h0000_04A0;
   localparam logic [31:0] ADDR_STATUS  = 32'h0000_04A4;

   typedef enum logic {IDLE, NORM} state_t;

   state_t      state, state_next;
   logic        sign, sign_next;
   logic [31:0] mag, mag_next;
   logic [7:0]  exp, exp_next;
   logic [31:0] fres, fres_next;
   logic        busy, busy_next;
   logic        done, done_next;
   logic [31:0] result_next;

   logic        start;
   logic [31:0] abs_in;

   assign start  = MemWrite && (Data_Addr == ADDR_OPERAND);
   // 0x80000000 negates to itself, which is the correct unsigned magnitude
   assign abs_in = Data_In[31] ? (~Data_In + 32'd1) : Data_In;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         sign   <= 1'b0;
         mag    <= '0;
         exp    <= '0;
         fres   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Result <= '0;
      end else begin
         state  <= state_next;
         sign   <= sign_next;
         mag    <= mag_next;
         exp    <= exp_next;
         fres   <= fres_next;
         busy   <= busy_next;
         done   <= done_next;
         Result <= result_next;
      end
   end

   // A new operand always wins over an in-flight normalisation step
   always_comb begin
      state_next = state;
      sign_next  = sign;
      mag_next   = mag;
      exp_next   = exp;
      fres_next  = fres;
      busy_next  = busy;
      done_next  = done;

      if (start) begin
         sign_next = Data_In[31];
         mag_next  = abs_in;
         exp_next  = 8'd158;
         done_next = 1'b0;
         if (Data_In == 32'd0) begin
            fres_next  = '0;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end else begin
            busy_next  = 1'b1;
            state_next = NORM;
         end
      end else if (state == NORM) begin
         if (!mag[31]) begin
            mag_next = {mag[30:0], 1'b0};
            exp_next = exp - 8'd1;
         end else begin
            fres_next  = {sign, exp, mag[30:8]};
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
         end
      end
   end

   always_comb begin
      result_next = fres;
      if (Data_Addr == ADDR_STATUS)
         result_next = {30'b0, done, busy};
   end

endmodule

// File: tb/tb_int_to_float_converter.sv
// Self-checking bench for int_to_float_converter using an arithmetic
// reference model of integer-to-float conversion with truncation.
module tb_int_to_float_converter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] Data_Addr = 32'h0;
   logic [31:0] Data_In = 32'h0;
   logic        MemWrite = 1'b0;
   logic [31:0] Result;

   int checks = 0;
   int errors = 0;

   int_to_float_converter dut (
      .clk(clk),
      .reset(reset),
      .Data_Addr(Data_Addr),
      .Data_In(Data_In),
      .MemWrite(MemWrite),
      .Result(Result)
   );

   always #5 clk = ~clk;

   // Exact float of the integer, mantissa truncated toward zero
   function automatic logic [31:0] ref_float(input logic [31:0] v);
      longint a;
      longint mant;
      int p;
      a = longint'($signed(v));
      if (a < 0) a = -a;
      if (a == 0) return 32'h0;
      p = 0;
      while ((64'sd1 <<< (p + 1)) <= a) p++;
      mant = a - (64'sd1 <<< p);
      if (p >= 23) mant = mant >>> (p - 23);
      else         mant = mant <<< (23 - p);
      return {v[31], 8'(127 + p), mant[22:0]};
   endfunction

   // Cycles from the start edge until done is visible
   function automatic int ref_latency(input logic [31:0] v);
      longint a;
      int p;
      a = longint'($signed(v));
      if (a < 0) a = -a;
      if (a == 0) return 0;
      p = 0;
      while ((64'sd1 <<< (p + 1)) <= a) p++;
      return 32 - p;
   endfunction

   task automatic write_op(input logic [31:0] v);
      @(negedge clk);
      Data_Addr = 32'h4A0;
      Data_In   = v;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      MemWrite  = 1'b0;
      Data_Addr = 32'h4A4;
   endtask

   // Result lags the address by an edge, so status after Ej reflects state after E(j-1)
   task automatic watch_conversion(input logic [31:0] v, input string name);
      int lat;
      logic [31:0] want;
      lat = ref_latency(v);
      for (int j = 1; j <= lat + 1; j++) begin
         @(posedge clk);
         #1;
         want = (j <= lat) ? 32'h1 : 32'h2;
         checks++;
         if (Result !== want) begin
            errors++;
            $display("[TB] FAIL %s status cycle %0d: got %h expected %h", name, j, Result, want);
         end
      end
      @(negedge clk);
      Data_Addr = 32'h4A8;
      @(posedge clk);
      #1;
      checks++;
      if (Result !== ref_float(v)) begin
         errors++;
         $display("[TB] FAIL %s result of %h: got %h expected %h", name, v, Result, ref_float(v));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (Result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_result: got %h expected %h", Result, 32'h0);
      end
      @(negedge clk);
      reset = 1'b0;
      Data_Addr = 32'h4A4;
      @(posedge clk);
      #1;
      checks++;
      if (Result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_status: got %h expected %h", Result, 32'h0);
      end
   endtask

   task automatic test_directed();
      logic [31:0] vals [7];
      vals = '{32'h1, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3, 32'h64};
      for (int i = 0; i < 7; i++) begin
         write_op(vals[i]);
         watch_conversion(vals[i], "directed");
      end
   endtask

   task automatic test_abort();
      write_op(32'h1);
      repeat (4) @(posedge clk);
      write_op(32'h10);
      watch_conversion(32'h10, "abort");
      checks++;
      if (Result !== 32'h4180_0000) begin
         errors++;
         $display("[TB] FAIL abort_value: got %h expected %h", Result, 32'h4180_0000);
      end
   endtask

   task automatic test_reset_midflight();
      write_op(32'h1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (Result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midreset_result: got %h expected %h", Result, 32'h0);
      end
      @(negedge clk);
      reset = 1'b0;
      Data_Addr = 32'h4A4;
      @(posedge clk);
      #1;
      checks++;
      if (Result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midreset_status: got %h expected %h", Result, 32'h0);
      end
      @(negedge clk);
      Data_Addr = 32'h4A8;
      @(posedge clk);
      #1;
      checks++;
      if (Result !== 32'h0) begin
         errors++;
         $display("[TB] FAIL midreset_fres: got %h expected %h", Result, 32'h0);
      end
      write_op(32'h64);
      watch_conversion(32'h64, "after_reset");
   endtask

   task automatic test_non_start();
      logic [31:0] want;
      write_op(32'h3);
      watch_conversion(32'h3, "pre_nonstart");
      want = ref_float(32'h3);
      @(negedge clk);
      Data_Addr = 32'h4A0;
      Data_In   = 32'h5;
      MemWrite  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      Data_Addr = 32'h4A8;
      Data_In   = 32'h7;
      MemWrite  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Data_Addr = 32'h4A4;
      MemWrite  = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (Result !== 32'h2) begin
         errors++;
         $display("[TB] FAIL nonstart_status: got %h expected %h", Result, 32'h2);
      end
      @(negedge clk);
      Data_Addr = 32'h480;
      @(posedge clk);
      #1;
      checks++;
      if (Result !== want) begin
         errors++;
         $display("[TB] FAIL default_read: got %h expected %h", Result, want);
      end
   endtask

   task automatic test_random();
      logic [31:0] v;
      for (int i = 0; i < 24; i++) begin
         v = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) v = -v;
         write_op(v);
         watch_conversion(v, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_abort();
      test_reset_midflight();
      test_non_start();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
